// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_GROUP_W = 4;

  typedef struct packed {
    logic p;
    logic g;
  } cla_pg_t;

  // Returns 0 when WIDTH cannot be split evenly into stages.
  // The top refuses to elaborate in that case.
  function automatic int cla_nstage(input int width, input int gps);
    if (gps < 1) return 0;
    if (width % (CLA_GROUP_W * gps) != 0) return 0;
    return width / (CLA_GROUP_W * gps);
  endfunction

  function automatic cla_pg_t cla_group_pg(
    input logic [3:0] p,
    input logic [3:0] g
  );
    cla_pg_t r;
    r.p = &p;
    r.g = g[3]
        | (p[3] & g[2])
        | (p[3] & p[2] & g[1])
        | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// in_sub exists only when CLA_PIPE_SUB_EN is defined.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
`ifdef CLA_PIPE_SUB_EN
  logic             in_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_pm;
  logic             out_gm;

  modport slave (
    input  in_valid, in_a, in_b, in_cin,
`ifdef CLA_PIPE_SUB_EN
    input  in_sub,
`endif
    input  out_ready,
    output in_ready, out_valid, out_sum,
    output out_cout, out_pm, out_gm
  );

  modport master (
    output in_valid, in_a, in_b, in_cin,
`ifdef CLA_PIPE_SUB_EN
    output in_sub,
`endif
    output out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_cout, out_pm, out_gm
  );

endinterface

// File: rtl/cla_pipe_stage.sv
// One pipeline slice: G-group lookahead over its bit window plus
// the register slice (sum-so-far, remaining operands, carry, pm/gm).
module cla_pipe_stage
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int G     = 2,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_v,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  input  logic             i_pm,
  input  logic             i_gm,
  output logic             o_v,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_b,
  output logic             o_c,
  output logic             o_pm,
  output logic             o_gm
);

  localparam int SW = CLA_GROUP_W * G;
  localparam int LO = K * SW;

  logic [SW-1:0]    w_p;
  logic [SW-1:0]    w_g;
  logic [SW-1:0]    w_s;
  logic             w_co;
  logic             w_pm;
  logic             w_gm;
  logic [WIDTH-1:0] w_xn;
  logic [WIDTH-1:0] w_bn;

  logic             r_v;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic             r_pm;
  logic             r_gm;

  always_comb begin
    logic    c;
    logic    gc;
    logic    pm;
    logic    gm;
    cla_pg_t pg;
    c  = 1'b0;
    gc = i_c;
    pm = 1'b1;
    gm = 1'b0;
    pg = '0;
    w_p = i_x[LO +: SW] ^ i_b[LO +: SW];
    w_g = i_x[LO +: SW] & i_b[LO +: SW];
    w_s = '0;
    for (int j = 0; j < G; j++) begin
      pg = cla_group_pg(w_p[j*4 +: 4], w_g[j*4 +: 4]);
      c  = gc;
      for (int i = 0; i < 4; i++) begin
        w_s[j*4+i] = w_p[j*4+i] ^ c;
        c = w_g[j*4+i] | (w_p[j*4+i] & c);
      end
      gc = pg.g | (pg.p & gc);
      pm = pm & pg.p;
      gm = pg.g | (pg.p & gm);
    end
    w_co = gc;
    w_pm = pm;
    w_gm = gm;
    // Consumed window: A slot now carries sum, B slot is cleared.
    w_xn = i_x;
    w_xn[LO +: SW] = w_s;
    w_bn = i_b;
    w_bn[LO +: SW] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v  <= 1'b0;
      r_x  <= '0;
      r_b  <= '0;
      r_c  <= 1'b0;
      r_pm <= 1'b0;
      r_gm <= 1'b0;
    end else if (i_en) begin
      r_v <= i_v;
      if (i_v) begin
        r_x  <= w_xn;
        r_b  <= w_bn;
        r_c  <= w_co;
        r_pm <= i_pm & w_pm;
        r_gm <= w_gm | (w_pm & i_gm);
      end
    end
  end

  assign o_v  = r_v;
  assign o_x  = r_x;
  assign o_b  = r_b;
  assign o_c  = r_c;
  assign o_pm = r_pm;
  assign o_gm = r_gm;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder with valid/ready on both sides.
// Define CLA_PIPE_SUB_EN to add the in_sub (a - b) request.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int GROUPS_PER_STAGE = 2
) (
  input logic              clk,
  input logic              rst_n,
  cla_pipe_adder_if.slave  bus
);

  localparam int NSTAGE = cla_nstage(WIDTH, GROUPS_PER_STAGE);

  if (NSTAGE < 1) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of 4*GROUPS_PER_STAGE");
  end

  logic [NSTAGE:0]   w_v;
  logic [NSTAGE:0]   w_c;
  logic [NSTAGE:0]   w_pm;
  logic [NSTAGE:0]   w_gm;
  logic [NSTAGE-1:0] w_en;
  logic [WIDTH-1:0]  w_x [NSTAGE+1];
  logic [WIDTH-1:0]  w_b [NSTAGE+1];
  logic [WIDTH-1:0]  w_b0;
  logic              w_c0;

`ifdef CLA_PIPE_SUB_EN
  assign w_b0 = bus.in_b ^ {WIDTH{bus.in_sub}};
  assign w_c0 = bus.in_cin ^ bus.in_sub;
`else
  assign w_b0 = bus.in_b;
  assign w_c0 = bus.in_cin;
`endif

  assign w_v[0]  = bus.in_valid;
  assign w_x[0]  = bus.in_a;
  assign w_b[0]  = w_b0;
  assign w_c[0]  = w_c0;
  assign w_pm[0] = 1'b1;
  assign w_gm[0] = 1'b0;

  // Stage k may load unless it and everything below it is full
  // and the consumer is stalled; empty stages always collapse.
  always_comb begin
    logic full;
    full = 1'b1;
    w_en = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      full    = full & w_v[k+1];
      w_en[k] = bus.out_ready | ~full;
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    cla_pipe_stage #(
      .WIDTH (WIDTH),
      .G     (GROUPS_PER_STAGE),
      .K     (k)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_en[k]),
      .i_v   (w_v[k]),
      .i_x   (w_x[k]),
      .i_b   (w_b[k]),
      .i_c   (w_c[k]),
      .i_pm  (w_pm[k]),
      .i_gm  (w_gm[k]),
      .o_v   (w_v[k+1]),
      .o_x   (w_x[k+1]),
      .o_b   (w_b[k+1]),
      .o_c   (w_c[k+1]),
      .o_pm  (w_pm[k+1]),
      .o_gm  (w_gm[k+1])
    );
  end

  assign bus.in_ready  = w_en[0];
  assign bus.out_valid = w_v[NSTAGE];
  assign bus.out_sum   = w_x[NSTAGE];
  assign bus.out_cout  = w_c[NSTAGE];
  assign bus.out_pm    = w_pm[NSTAGE];
  assign bus.out_gm    = w_gm[NSTAGE];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (32/2 and 12/3 builds).
module tb_cla_pipe_adder;

  localparam int NST = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        pm;
    logic        gm;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        pm;
    logic        gm;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(32)) bus ();
  cla_pipe_adder_if #(.WIDTH(12)) bus12 ();

  cla_pipe_adder #(.WIDTH(32), .GROUPS_PER_STAGE(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  cla_pipe_adder #(.WIDTH(12), .GROUPS_PER_STAGE(3)) dut12 (
    .clk(clk), .rst_n(rst_n), .bus(bus12)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_ret = 0;
  int   cyc = 0;
  int   last_acc_cyc = -100;
  int   last_ret_cyc = -100;
  res_t q[$];
  int   retc[$];
  res_t pend;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [31:0] be;
    logic [32:0] t0;
    logic [32:0] t;
    res_t r;
    be = sub ? ~b : b;
    t0 = {1'b0, a} + {1'b0, be};
    t = t0 + {32'd0, cin ^ sub};
    r.sum = t[31:0];
    r.cout = t[32];
    r.pm = &(a ^ be);
    r.gm = t0[32];
    return r;
  endfunction

  function automatic logic [31:0] pat_a(input int i);
    return 32'h89AB_CDEF + 32'(i) * 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pat_b(input int i);
    return 32'hFEDC_BA98 ^ (32'(i) * 32'h0F0F_1234);
  endfunction

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic cin,
                       input logic sub);
    bus.in_valid = v;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_cin = cin;
`ifdef CLA_PIPE_SUB_EN
    bus.in_sub = sub;
`endif
    pend = model(a, b, cin, sub);
  endtask

  task automatic tick(input string tag);
    res_t e;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      n_ret++;
      last_ret_cyc = cyc;
      retc.push_back(cyc);
      if (q.size() == 0) begin
        chk({tag, "_extra"}, 32'(bus.out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk({tag, "_sum"}, bus.out_sum, e.sum);
        chk({tag, "_cout"}, 32'(bus.out_cout), 32'(e.cout));
        chk({tag, "_pm"}, 32'(bus.out_pm), 32'(e.pm));
        chk({tag, "_gm"}, 32'(bus.out_gm), 32'(e.gm));
      end
    end else if (bus.out_valid && q.size() != 0) begin
      chk({tag, "_hold"}, bus.out_sum, q[0].sum);
    end
    if (bus.in_valid && bus.in_ready) begin
      q.push_back(pend);
      n_acc++;
      last_acc_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic one_beat(input vec_t v, input string nm);
    int n0;
    bus.out_ready = 1'b1;
    drive(1'b1, v.a, v.b, v.cin, v.sub);
    pend = '{sum: v.sum, cout: v.cout, pm: v.pm, gm: v.gm};
    n0 = n_ret;
    tick(nm);
    chk({nm, "_acc"}, 32'(last_acc_cyc), 32'(cyc - 1));
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) if (n_ret == n0) tick(nm);
    chk({nm, "_lat"}, 32'(last_ret_cyc - last_acc_cyc), 32'(NST));
    chk({nm, "_cnt"}, 32'(n_ret - n0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int a0;
    int j;

    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_cin = 1'b0;
    bus.out_ready = 1'b1;
    bus12.in_valid = 1'b0;
    bus12.in_a = '0;
    bus12.in_b = '0;
    bus12.in_cin = 1'b0;
    bus12.out_ready = 1'b1;
`ifdef CLA_PIPE_SUB_EN
    bus.in_sub = 1'b0;
    bus12.in_sub = 1'b0;
`endif

    tbl[0] = '{32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
               32'h2345_6789, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
               32'h0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
               32'h8000_0000, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0,
               32'h0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0,
               32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0,
               32'h0001_FFFF, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_sum", bus.out_sum, 32'd0);
    chk("rst_cout", 32'(bus.out_cout), 32'd0);
    chk("rst_pm", 32'(bus.out_pm), 32'd0);
    chk("rst_gm", 32'(bus.out_gm), 32'd0);
    chk("rst12_valid", 32'(bus12.out_valid), 32'd0);
    chk("rst12_ready", 32'(bus12.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) one_beat(tbl[i], $sformatf("vec%0d", i));

    // Eight back-to-back beats.
    retc.delete();
    n0 = n_ret;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, pat_a(i), pat_b(i), (i % 2) == 1, 1'b0);
      #1;
      chk("b2b_rdy", 32'(bus.in_ready), 32'd1);
      tick("b2b");
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (NST + 6) tick("b2b");
    chk("b2b_cnt", 32'(n_ret - n0), 32'd8);
    chk("b2b_span",
        32'(retc.size() == 8 ? retc[7] - retc[0] : -1), 32'd7);

    // Backpressure for 6 cycles, then release.
    bus.out_ready = 1'b0;
    a0 = n_acc;
    n0 = n_ret;
    j = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, pat_a(10 + j), pat_b(10 + j), (j % 2) == 1, 1'b0);
      #1;
      if (c == 5) chk("stall_rdy", 32'(bus.in_ready), 32'd0);
      tick("stall");
      j = n_acc - a0;
    end
    chk("stall_acc", 32'(n_acc - a0), 32'd4);
    chk("stall_noret", 32'(n_ret - n0), 32'd0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && j < 8; c++) begin
      drive(1'b1, pat_a(10 + j), pat_b(10 + j), (j % 2) == 1, 1'b0);
      tick("drain");
      j = n_acc - a0;
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (NST + 4) tick("drain");
    chk("drain_ret", 32'(n_ret - n0), 32'd8);
    chk("drain_q", 32'(q.size()), 32'd0);

    // Reset with three beats in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pat_a(20 + i), pat_b(20 + i), 1'b1, 1'b0);
      tick("inflt");
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick("inflt");
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_sum", bus.out_sum, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    n0 = n_ret;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, pat_a(40 + i), pat_b(40 + i), 1'b0, 1'b0);
      tick("post");
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (NST + 4) tick("post");
    chk("post_cnt", 32'(n_ret - n0), 32'd2);
    chk("post_q", 32'(q.size()), 32'd0);

    // Single-stage build: 12 bits, 3 groups per stage.
    bus12.in_valid = 1'b1;
    bus12.in_a = 12'hABC;
    bus12.in_b = 12'h544;
    bus12.in_cin = 1'b0;
    #1;
    chk("w12_ready", 32'(bus12.in_ready), 32'd1);
    @(negedge clk);
    bus12.in_valid = 1'b0;
    #1;
    chk("w12_valid", 32'(bus12.out_valid), 32'd1);
    chk("w12_sum", 32'(bus12.out_sum), 32'h000);
    chk("w12_cout", 32'(bus12.out_cout), 32'd1);
    chk("w12_pm", 32'(bus12.out_pm), 32'd0);
    chk("w12_gm", 32'(bus12.out_gm), 32'd1);
    @(negedge clk);
    #1;
    chk("w12_done", 32'(bus12.out_valid), 32'd0);
    @(negedge clk);

`ifdef CLA_PIPE_SUB_EN
    one_beat('{32'h5, 32'h7, 1'b0, 1'b1,
               32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}, "sub5m7");
    one_beat('{32'h7, 32'h5, 1'b0, 1'b1,
               32'h2, 1'b1, 1'b0, 1'b1}, "sub7m5");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
